// File: rtl/rv32i_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Purpose  : Shared RV32I definitions for the immediate encode/decode path:
//            immediate-type codes (same encoding as signextnd), opcode
//            constants, the buffered encoder result record and a helper that
//            tests whether the upper bits of a word are a pure sign run.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  // Immediate format selector, shared with the decode-side signextnd.
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_type_e;

  // Base opcodes that carry an immediate.
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // Output buffer geometry.
  localparam int unsigned ENC_FIFO_DEPTH = 2;
  localparam int unsigned ERR_CNT_W      = 8;

  // Masks covering the bits that must all equal the sign bit for the value
  // to be representable in each signed format.
  localparam logic [31:0] SIGN_MASK_IS = 32'hFFFF_F800; // 12-bit signed
  localparam logic [31:0] SIGN_MASK_B  = 32'hFFFF_F000; // 13-bit signed
  localparam logic [31:0] SIGN_MASK_J  = 32'hFFF0_0000; // 21-bit signed

  // One buffered encoder result.
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_word_t;

  // True when every bit selected by mask is 0, or every one is 1.
  function automatic logic sign_run_ok(input logic [31:0] value,
                                       input logic [31:0] mask);
    logic [31:0] sel;
    sel = value & mask;
    return (sel == 32'h0) || (sel == mask);
  endfunction

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/imm_fmt_pack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imm_fmt_pack
// Purpose  : Purely combinational RV32I instruction assembler. Scatters the
//            immediate into the bit positions of the selected format, merges
//            the register/function fields and flags values that the format
//            cannot represent.
// Ports    : in_imm       32  immediate (two's complement / upper value)
//            in_imm_type   3  format code (I,S,B,J,U; others invalid)
//            in_opcode     7  instr[6:0]
//            in_rd/rs1/rs2 5  register fields
//            in_funct3     3  instr[14:12]
//            out_instr    32  assembled word (zero for an invalid type)
//            out_err       1  immediate out of range or type invalid
// Revision : 1.0 - initial release
// ============================================================================
module imm_fmt_pack
  import rv32i_pkg::*;
(
  input  logic [31:0] in_imm,
  input  logic [2:0]  in_imm_type,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  output logic [31:0] out_instr,
  output logic        out_err
);

  imm_type_e imm_type;
  assign imm_type = imm_type_e'(in_imm_type);

  // Even when the range check fails the word is still built from the
  // truncated bits, so a consumer can inspect what would have been emitted.
  always_comb begin
    out_instr = 32'h0;
    out_err   = 1'b1;
    case (imm_type)
      IMM_I: begin
        out_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        out_err   = !sign_run_ok(in_imm, SIGN_MASK_IS);
      end
      IMM_S: begin
        out_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        out_err   = !sign_run_ok(in_imm, SIGN_MASK_IS);
      end
      IMM_B: begin
        out_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        // Branch offsets are halfword aligned; bit 0 is not encodable.
        out_err   = in_imm[0] || !sign_run_ok(in_imm, SIGN_MASK_B);
      end
      IMM_J: begin
        out_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                     in_rd, in_opcode};
        out_err   = in_imm[0] || !sign_run_ok(in_imm, SIGN_MASK_J);
      end
      IMM_U: begin
        out_instr = {in_imm[31:12], in_rd, in_opcode};
        // The low 12 bits have no home in a U word and must be clear.
        out_err   = (in_imm[11:0] != 12'h0);
      end
      default: begin
        out_instr = 32'h0;
        out_err   = 1'b1;
      end
    endcase
  end

endmodule : imm_fmt_pack
`default_nettype wire

// File: rtl/imm_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imm_encoder
// Purpose  : Assembles complete RV32I words from immediate + fields, buffers
//            them in a 2-entry FIFO with valid/ready on both sides and keeps a
//            saturating count of accepted erroneous requests.
// Ports    : clk, rst            clock, synchronous active-high reset
//            in_valid/in_ready   request handshake
//            in_imm[31:0], in_imm_type[2:0], in_opcode[6:0],
//            in_rd/in_rs1/in_rs2[4:0], in_funct3[2:0]   request fields
//            out_valid/out_ready result handshake
//            out_instr[31:0]     head word (zero while empty)
//            out_err             head entry failed range/type check
//            err_count[7:0]      saturating error counter
// Revision : 1.0 - initial release
// ============================================================================
module imm_encoder
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_imm,
  input  logic [2:0]  in_imm_type,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [1:0]           CNT_FULL = 2'(ENC_FIFO_DEPTH);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // Encoder
  // --------------------------------------------------------------------------
  logic [31:0] pack_instr;
  logic        pack_err;

  imm_fmt_pack u_pack (
    .in_imm      (in_imm),
    .in_imm_type (in_imm_type),
    .in_opcode   (in_opcode),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_funct3   (in_funct3),
    .out_instr   (pack_instr),
    .out_err     (pack_err)
  );

  // --------------------------------------------------------------------------
  // FIFO state
  // --------------------------------------------------------------------------
  enc_word_t            mem_q [ENC_FIFO_DEPTH];
  enc_word_t            mem_d [ENC_FIFO_DEPTH];
  logic [1:0]           count_q, count_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic      push;
  logic      pop;
  enc_word_t head;

  // in_ready comes from registered occupancy only, so a full FIFO refuses a
  // push even in a cycle where the head is popped.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head      = mem_q[rd_ptr_q];
  assign out_instr = out_valid ? head.instr : 32'h0;
  assign out_err   = out_valid ? head.err   : 1'b0;
  assign err_count = err_count_q;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_count_d = err_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{instr: pack_instr, err: pack_err};
      wr_ptr_d        = ~wr_ptr_q;
      if (pack_err && (err_count_q != ERR_MAX)) begin
        err_count_d = err_count_q + 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_count_q <= err_count_d;
    end
  end

endmodule : imm_encoder
`default_nettype wire
